cmd_dispatcher: RTL
===================

// Module: cmd_dispatcher
// PURPOSE
//  Sequences the scoreboard: round-robin arbitration of N_REQ command requesters
//  onto PROC_COUNT processor cores. Allocates a free core, writes {cmd_id, core_id}
//  into the scoreboard, then issues the command to that core.
//  On core completion it flushes the entry from the scoreboard and frees the core.
//  Sits between the command issuers and the scoreboard / core array.
// PARAMETERS
//  N_REQ        4  number of requesters (>=2)
//  PROC_COUNT   4  number of cores, power of 2
//  CMD_ID_WIDTH 8  command id width; cmd_id 0 is reserved (scoreboard empty key)
//  CORE_W       $clog2(PROC_COUNT)  core id width
// PORTS
//  i_clk          in  1                   clock, rising edge
//  i_rst          in  1                   async reset, active-high
//  i_req_valid    in  N_REQ               per-requester command valid
//  i_req_cmd_id   in  N_REQ*CMD_ID_WIDTH  packed cmd ids; requester r at [r*W +: W]
//  o_req_ready    out N_REQ               1-cycle accept pulse, one-hot
//  o_req_err      out 1                   1-cycle pulse with o_req_ready: cmd_id==0 rejected
//  o_sb_write     out 1                   scoreboard write request, level until ack
//  o_sb_flush     out 1                   scoreboard flush request, level until ack
//  o_sb_cmd_id    out CMD_ID_WIDTH        key for write/flush
//  o_sb_core_id   out CORE_W              core id stored on write
//  i_sb_ack       in  1                   scoreboard completed current write/flush
//  i_done         in  PROC_COUNT          per-core completion pulse
//  o_issue_valid  out 1                   1-cycle pulse: command launched
//  o_issue_core   out CORE_W              target core of o_issue_valid
//  o_issue_cmd_id out CMD_ID_WIDTH        cmd id of o_issue_valid
//  o_busy         out PROC_COUNT          core allocated (write started, flush not acked)
// BEHAVIOUR
//  Reset (async, any state): all outputs 0, FSM=S_IDLE, rr_ptr=0, busy=0,
//   done_pend=0, per-core cmd table=0. In-flight write/flush is abandoned.
//  done_pend[c] set on i_done[c] when busy[c]; i_done on a non-busy core is ignored.
//  FSM, one transition per clock:
//   S_IDLE: priority 1: any done_pend -> pick lowest c, load cmd/core regs, -> S_FLUSH.
//           priority 2: any i_req_valid and any free core -> grant first valid requester
//           at or after rr_ptr (wrapping N_REQ-1 -> 0).
//             cmd_id==0: pulse o_req_ready[g] + o_req_err next cycle, rr_ptr<=g+1, stay idle.
//             else: latch cmd_id, alloc lowest free core, set busy, -> S_WRITE.
//           neither: stay.
//   S_WRITE: o_sb_write=1 with cmd/core; on i_sb_ack -> S_ISSUE.
//   S_ISSUE: one cycle: o_issue_valid=1, o_req_ready[g]=1, table[core]<=cmd_id,
//            rr_ptr<=g+1 (mod N_REQ) -> S_IDLE.
//   S_FLUSH: o_sb_flush=1 with table[c]; on i_sb_ack: busy[c]=0, done_pend[c]=0,
//            table[c]=0 -> S_IDLE.
//  Latency, no contention, ack same cycle it is requested:
//   valid -> issue/ready = 3 clocks (IDLE, WRITE, ISSUE).
//   done -> core free = 3 clocks.
//  Requester must hold valid and cmd_id stable until its ready pulse.
//  Dropping valid before grant is legal; once latched, the command completes regardless.
//  o_sb_write and o_sb_flush are never both 1; at most one scoreboard op outstanding.
//  All cores busy: requests stall, ready stays 0, flushes still served.
//  i_done arriving while another flush is in S_FLUSH is retained in done_pend.
//  i_done for the core just allocated in S_WRITE/S_ISSUE is captured (busy already 1).
//  Flush has priority over new grants; a grant never starves, because flushes are
//   bounded by PROC_COUNT.
// TESTING
//  1 Reset mid-S_WRITE (i_rst pulse) -> all outputs 0 same cycle; busy=0; next req starts at requester 0.
//  2 req0 cmd 0x05, ack immediate -> sb_write{05,core0} at cyc1; issue core0 + ready[0] at cyc2.
//  3 req0..3 valid continuously, PROC_COUNT=4, acks immediate, all done -> grants in order 0,1,2,3,0.
//  4 Four cmds busy all cores, req1 valid -> no ready until i_done[2]; flush(cmd of core2) acked; then req1 -> core2.
//  5 req2 cmd_id 0 -> ready[2] + req_err pulse; no sb_write; busy unchanged.
//  6 i_done[1] and i_done[3] same cycle -> flush core1 then core3 before next grant; i_done on idle core0 -> ignored.

Source files
------------

// File: rtl/cmd_dispatcher.sv
// Round-robin command dispatcher: grants requesters onto free cores, records
// {cmd_id, core_id} in the scoreboard, issues the command and flushes it on completion.
module cmd_dispatcher #(
  parameter int N_REQ        = 4,
  parameter int PROC_COUNT   = 4,
  parameter int CMD_ID_WIDTH = 8,
  parameter int CORE_W       = $clog2(PROC_COUNT)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req_valid,
  input  logic [N_REQ*CMD_ID_WIDTH-1:0] i_req_cmd_id,
  output logic [N_REQ-1:0]              o_req_ready,
  output logic                          o_req_err,
  output logic                          o_sb_write,
  output logic                          o_sb_flush,
  output logic [CMD_ID_WIDTH-1:0]       o_sb_cmd_id,
  output logic [CORE_W-1:0]             o_sb_core_id,
  input  logic                          i_sb_ack,
  input  logic [PROC_COUNT-1:0]         i_done,
  output logic                          o_issue_valid,
  output logic [CORE_W-1:0]             o_issue_core,
  output logic [CMD_ID_WIDTH-1:0]       o_issue_cmd_id,
  output logic [PROC_COUNT-1:0]         o_busy
);

  localparam int RR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ISSUE, S_FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [RR_W-1:0]         rrPtr_q, rrPtr_d;
  logic [RR_W-1:0]         grant_q, grant_d;
  logic [CMD_ID_WIDTH-1:0] cmdId_q, cmdId_d;
  logic [CORE_W-1:0]       coreId_q, coreId_d;
  logic                    err_q, err_d;
  logic [PROC_COUNT-1:0]   busy_q, donePend_q;
  logic [CMD_ID_WIDTH-1:0] cmdTable_q [PROC_COUNT];

  logic                    reqFound;
  logic [RR_W-1:0]         reqIdx;
  logic [CMD_ID_WIDTH-1:0] reqCmd;
  logic                    freeFound;
  logic [CORE_W-1:0]       freeIdx;
  logic                    pendFound;
  logic [CORE_W-1:0]       pendIdx;
  logic [PROC_COUNT-1:0]   busySet, busyClr;
  logic                    tblWrite, tblClear;

  function automatic logic [RR_W-1:0] nextPtr(input logic [RR_W-1:0] p);
    if (int'(p) >= N_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin : p_arb
    int cand;
    logic [RR_W-1:0] candIdx;
    cand     = 0;
    candIdx  = '0;
    reqFound = 1'b0;
    reqIdx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(rrPtr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      candIdx = RR_W'(cand);
      if (!reqFound && i_req_valid[candIdx]) begin
        reqFound = 1'b1;
        reqIdx   = candIdx;
      end
    end
    reqCmd = '0;
    for (int r = 0; r < N_REQ; r++) begin
      if (reqIdx == RR_W'(r)) reqCmd = i_req_cmd_id[r*CMD_ID_WIDTH +: CMD_ID_WIDTH];
    end
  end

  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    pendFound = 1'b0;
    pendIdx   = '0;
    for (int c = 0; c < PROC_COUNT; c++) begin
      if (!freeFound && !busy_q[c]) begin
        freeFound = 1'b1;
        freeIdx   = CORE_W'(c);
      end
      if (!pendFound && donePend_q[c]) begin
        pendFound = 1'b1;
        pendIdx   = CORE_W'(c);
      end
    end
  end

  // A zero-id reject holds off granting for the cycle its ready pulse is visible,
  // so the still-asserted requester is not accepted twice.
  always_comb begin
    state_d        = state_q;
    rrPtr_d        = rrPtr_q;
    grant_d        = grant_q;
    cmdId_d        = cmdId_q;
    coreId_d       = coreId_q;
    err_d          = 1'b0;
    busySet        = '0;
    busyClr        = '0;
    tblWrite       = 1'b0;
    tblClear       = 1'b0;
    o_req_ready    = '0;
    o_req_err      = err_q;
    o_sb_write     = 1'b0;
    o_sb_flush     = 1'b0;
    o_sb_cmd_id    = '0;
    o_sb_core_id   = '0;
    o_issue_valid  = 1'b0;
    o_issue_core   = '0;
    o_issue_cmd_id = '0;
    if (err_q) o_req_ready[grant_q] = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (pendFound) begin
          coreId_d = pendIdx;
          cmdId_d  = cmdTable_q[pendIdx];
          state_d  = S_FLUSH;
        end else if (reqFound && freeFound && !err_q) begin
          grant_d = reqIdx;
          if (reqCmd == '0) begin
            err_d   = 1'b1;
            rrPtr_d = nextPtr(reqIdx);
          end else begin
            cmdId_d          = reqCmd;
            coreId_d         = freeIdx;
            busySet[freeIdx] = 1'b1;
            state_d          = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        o_sb_write   = 1'b1;
        o_sb_cmd_id  = cmdId_q;
        o_sb_core_id = coreId_q;
        if (i_sb_ack) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        o_issue_valid         = 1'b1;
        o_issue_core          = coreId_q;
        o_issue_cmd_id        = cmdId_q;
        o_req_ready[grant_q]  = 1'b1;
        tblWrite              = 1'b1;
        rrPtr_d               = nextPtr(grant_q);
        state_d               = S_IDLE;
      end
      S_FLUSH: begin
        o_sb_flush   = 1'b1;
        o_sb_cmd_id  = cmdId_q;
        o_sb_core_id = coreId_q;
        if (i_sb_ack) begin
          busyClr[coreId_q] = 1'b1;
          tblClear          = 1'b1;
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_busy = busy_q;

  // Completions are only remembered for allocated cores; a flush ack retires both flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rrPtr_q    <= '0;
      grant_q    <= '0;
      cmdId_q    <= '0;
      coreId_q   <= '0;
      err_q      <= 1'b0;
      busy_q     <= '0;
      donePend_q <= '0;
      for (int c = 0; c < PROC_COUNT; c++) cmdTable_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      grant_q    <= grant_d;
      cmdId_q    <= cmdId_d;
      coreId_q   <= coreId_d;
      err_q      <= err_d;
      busy_q     <= (busy_q | busySet) & ~busyClr;
      donePend_q <= (donePend_q | (i_done & busy_q)) & ~busyClr;
      for (int c = 0; c < PROC_COUNT; c++) begin
        if (tblWrite && coreId_q == CORE_W'(c)) cmdTable_q[c] <= cmdId_q;
        else if (tblClear && coreId_q == CORE_W'(c)) cmdTable_q[c] <= '0;
      end
    end
  end

endmodule
